// File: rtl/stream_serializer_pkg.sv
// Shared definitions for the stream serializer family: chunk-order constants,
// the chunk-index width helper and the serializer state encoding.
package stream_serializer_pkg;

    // Chunk order selectors, also used by the companion deserializer.
    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;

    // Number of bits needed to represent value (0 for value == 0).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of a chunk index for n chunks per word, never narrower than 1 bit.
    function automatic int cw_width(input int n);
        int b;
        b = clogb2(n - 1);
        return (b < 1) ? 1 : b;
    endfunction

    // Word-holding state: idle (nothing loaded) or active (word in flight).
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ser_state_t;

endpackage

// File: rtl/stream_serializer_if.sv
// Wide-in / narrow-out stream bundle. The serializer takes the slave view,
// the producer/consumer environment takes the master view.
interface stream_serializer_if
    import stream_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int CW = cw_width(N);

    logic [WIDTH*N-1:0] in_data;
    logic [CW-1:0]      in_last_idx;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_first;
    logic               out_last;

    modport slave (
        input  in_data, in_last_idx, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_first, out_last
    );

    modport master (
        output in_data, in_last_idx, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_first, out_last
    );

endinterface

// File: rtl/stream_serializer.sv
// N:1 width-down converter with valid/ready on both sides, per-word chunk
// count and selectable chunk order. Reloads with zero bubble on the last chunk.
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N         = 4,
    parameter int MSB_FIRST = ORDER_LSB_FIRST
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    output logic               busy,
    stream_serializer_if.slave bus
);
    localparam int CW = cw_width(N);
    localparam int SW = WIDTH * N;
    localparam logic [CW-1:0] MAX_IDX = CW'(N - 1);

    ser_state_t       state_reg, state_next;
    logic [SW-1:0]    store_reg, store_next;
    logic [CW-1:0]    idx_reg, idx_next;
    logic [CW-1:0]    last_idx_reg, last_idx_next;

    logic [SW-1:0]    store_shifted;
    logic [WIDTH-1:0] head_chunk;
    logic [CW-1:0]    clamped_last_idx;
    logic             loaded;
    logic             at_last;
    logic             out_fire;
    logic             in_fire;

    generate
        // Output end of the shift register and the direction it shifts toward.
        if (MSB_FIRST == ORDER_MSB_FIRST) begin : g_msb
            assign head_chunk    = store_reg[SW-1 -: WIDTH];
            assign store_shifted = {store_reg[SW-WIDTH-1:0], {WIDTH{1'b0}}};
        end else begin : g_lsb
            assign head_chunk    = store_reg[WIDTH-1:0];
            assign store_shifted = {{WIDTH{1'b0}}, store_reg[SW-1:WIDTH]};
        end

        // Clamping only matters when the index field can encode more than N chunks.
        if ((1 << CW) == N) begin : g_pow2
            assign clamped_last_idx = bus.in_last_idx;
        end else begin : g_clamp
            assign clamped_last_idx = (bus.in_last_idx > MAX_IDX) ? MAX_IDX : bus.in_last_idx;
        end
    endgenerate

    // Outputs come straight from registers; flags are masked while idle so
    // everything reads 0 out of reset.
    assign loaded        = (state_reg == ST_ACTIVE);
    assign at_last       = (idx_reg == last_idx_reg);
    assign bus.out_valid = loaded;
    assign bus.out_data  = head_chunk;
    assign bus.out_first = loaded && (idx_reg == '0);
    assign bus.out_last  = loaded && at_last;
    assign busy          = loaded;

    // in_ready depends combinationally on out_ready so the next word can load
    // in the same cycle the last chunk leaves.
    assign out_fire     = loaded && bus.out_ready;
    assign bus.in_ready = reset_n && !clear && (!loaded || (out_fire && at_last));
    assign in_fire      = bus.in_valid && bus.in_ready;

    // Next-state: clear aborts, then load, then advance on an accepted chunk.
    always_comb begin
        state_next    = state_reg;
        store_next    = store_reg;
        idx_next      = idx_reg;
        last_idx_next = last_idx_reg;
        if (clear) begin
            state_next = ST_IDLE;
            idx_next   = '0;
        end else if (in_fire) begin
            state_next    = ST_ACTIVE;
            store_next    = bus.in_data;
            idx_next      = '0;
            last_idx_next = clamped_last_idx;
        end else if (out_fire) begin
            if (at_last) begin
                state_next = ST_IDLE;
            end else begin
                store_next = store_shifted;
                idx_next   = idx_reg + CW'(1);
            end
        end
    end

    // State register; reset drops any word in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            store_reg    <= '0;
            idx_reg      <= '0;
            last_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            store_reg    <= store_next;
            idx_reg      <= idx_next;
            last_idx_reg <= last_idx_next;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: three instances (LSB-first N=4,
// MSB-first N=4, LSB-first N=3) with a per-instance expected-chunk queue
// drained by a monitor on every accepted chunk.
module tb_stream_serializer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic clear_a = 1'b0;
    logic clear_b = 1'b0;
    logic clear_c = 1'b0;
    logic busy_a, busy_b, busy_c;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } chunk_t;

    chunk_t q_a[$];
    chunk_t q_b[$];
    chunk_t q_c[$];

    always #5 clock = ~clock;

    stream_serializer_if #(.WIDTH(8), .N(4)) a_if ();
    stream_serializer_if #(.WIDTH(8), .N(4)) b_if ();
    stream_serializer_if #(.WIDTH(8), .N(3)) c_if ();

    stream_serializer #(.WIDTH(8), .N(4), .MSB_FIRST(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .clear(clear_a), .busy(busy_a), .bus(a_if.slave)
    );
    stream_serializer #(.WIDTH(8), .N(4), .MSB_FIRST(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .clear(clear_b), .busy(busy_b), .bus(b_if.slave)
    );
    stream_serializer #(.WIDTH(8), .N(3), .MSB_FIRST(0)) dut_c (
        .clock(clock), .reset_n(reset_n), .clear(clear_c), .busy(busy_c), .bus(c_if.slave)
    );

    function automatic chunk_t mk(input logic [7:0] d, input logic f, input logic l);
        chunk_t c;
        c.data  = d;
        c.first = f;
        c.last  = l;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic score(input string name, input chunk_t got, input bit have, input chunk_t exp);
        compared++;
        if (!have) begin
            mismatched++;
            $display("FAIL %s_unexpected_chunk: got data=0x%02h first=%0b last=%0b required nothing",
                     name, got.data, got.first, got.last);
        end else if (got !== exp) begin
            mismatched++;
            $display("FAIL %s_chunk: got data=0x%02h first=%0b last=%0b required data=0x%02h first=%0b last=%0b",
                     name, got.data, got.first, got.last, exp.data, exp.first, exp.last);
        end else begin
            $display("%s chunk data=0x%02h first=%0b last=%0b ok", name, got.data, got.first, got.last);
        end
    endtask

    // Monitor for instance a: every accepted chunk must match the queue head.
    always @(negedge clock) begin
        if (reset_n && !clear_a && a_if.out_valid && a_if.out_ready) begin
            if (q_a.size() != 0) score("a", {a_if.out_data, a_if.out_first, a_if.out_last}, 1'b1, q_a.pop_front());
            else                 score("a", {a_if.out_data, a_if.out_first, a_if.out_last}, 1'b0, '0);
        end
    end

    // Monitor for instance b.
    always @(negedge clock) begin
        if (reset_n && !clear_b && b_if.out_valid && b_if.out_ready) begin
            if (q_b.size() != 0) score("b", {b_if.out_data, b_if.out_first, b_if.out_last}, 1'b1, q_b.pop_front());
            else                 score("b", {b_if.out_data, b_if.out_first, b_if.out_last}, 1'b0, '0);
        end
    end

    // Monitor for instance c.
    always @(negedge clock) begin
        if (reset_n && !clear_c && c_if.out_valid && c_if.out_ready) begin
            if (q_c.size() != 0) score("c", {c_if.out_data, c_if.out_first, c_if.out_last}, 1'b1, q_c.pop_front());
            else                 score("c", {c_if.out_data, c_if.out_first, c_if.out_last}, 1'b0, '0);
        end
    end

    function automatic logic valid_of(input int which);
        case (which)
            0:       return a_if.out_valid;
            1:       return b_if.out_valid;
            default: return c_if.out_valid;
        endcase
    endfunction

    function automatic logic ready_of(input int which);
        case (which)
            0:       return a_if.in_ready;
            1:       return b_if.in_ready;
            default: return c_if.in_ready;
        endcase
    endfunction

    // Offer one word to an idle instance; returns #1 after the accepting edge.
    task automatic offer(input int which, input logic [31:0] d, input logic [1:0] li);
        case (which)
            0: begin a_if.in_data = d;       a_if.in_last_idx = li; a_if.in_valid = 1'b1; end
            1: begin b_if.in_data = d;       b_if.in_last_idx = li; b_if.in_valid = 1'b1; end
            default: begin c_if.in_data = d[23:0]; c_if.in_last_idx = li; c_if.in_valid = 1'b1; end
        endcase
        $display("offer dut%0d data=0x%0h last_idx=%0d", which, d, li);
        @(negedge clock);
        check($sformatf("offer%0d_in_ready", which), ready_of(which), 1);
        @(posedge clock); #1;
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        c_if.in_valid = 1'b0;
    endtask

    // Expect n consecutive valid cycles followed by an idle cycle.
    task automatic run_word(input int which, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            check($sformatf("run%0d_valid_c%0d", which, c), valid_of(which), 1);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check($sformatf("run%0d_idle", which), valid_of(which), 0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       bp_rdy  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] bp_data [8] = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD};
        logic       bp_inrdy[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        a_if.in_data = '0; a_if.in_last_idx = '0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_data = '0; b_if.in_last_idx = '0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
        c_if.in_data = '0; c_if.in_last_idx = '0; c_if.in_valid = 1'b0; c_if.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_busy",      busy_a,         0);
        check("rst_out_first", a_if.out_first, 0);
        check("rst_out_last",  a_if.out_last,  0);
        check("rst_out_data",  a_if.out_data,  0);
        check("rst_in_ready",  a_if.in_ready,  0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", a_if.in_ready, 1);
        @(posedge clock); #1;

        // Full word, LSB first.
        a_if.out_ready = 1'b1;
        q_a.push_back(mk(8'hAA, 1, 0)); q_a.push_back(mk(8'hBB, 0, 0));
        q_a.push_back(mk(8'hCC, 0, 0)); q_a.push_back(mk(8'hDD, 0, 1));
        offer(0, 32'hDDCCBBAA, 2'd3);
        run_word(0, 4);

        // Back-to-back words: in_ready only on the last chunk of each.
        q_a.push_back(mk(8'h11, 1, 0)); q_a.push_back(mk(8'h22, 0, 0));
        q_a.push_back(mk(8'h33, 0, 0)); q_a.push_back(mk(8'h44, 0, 1));
        q_a.push_back(mk(8'h55, 1, 0)); q_a.push_back(mk(8'h66, 0, 0));
        q_a.push_back(mk(8'h77, 0, 0)); q_a.push_back(mk(8'h88, 0, 1));
        a_if.in_data = 32'h44332211; a_if.in_last_idx = 2'd3; a_if.in_valid = 1'b1;
        @(negedge clock);
        check("b2b_first_in_ready", a_if.in_ready, 1);
        @(posedge clock); #1;
        a_if.in_data = 32'h88776655;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) a_if.in_valid = 1'b0;
            @(negedge clock);
            check($sformatf("b2b_valid_c%0d", c), a_if.out_valid, 1);
            check($sformatf("b2b_in_ready_c%0d", c), a_if.in_ready, (c == 3 || c == 7) ? 1 : 0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("b2b_idle", a_if.out_valid, 0);
        @(posedge clock); #1;

        // Backpressure: chunk held during stalls, in_ready only on final transfer.
        q_a.push_back(mk(8'hAA, 1, 0)); q_a.push_back(mk(8'hBB, 0, 0));
        q_a.push_back(mk(8'hCC, 0, 0)); q_a.push_back(mk(8'hDD, 0, 1));
        offer(0, 32'hDDCCBBAA, 2'd3);
        for (int c = 0; c < 8; c++) begin
            a_if.out_ready = bp_rdy[c];
            @(negedge clock);
            check($sformatf("bp_data_c%0d", c), a_if.out_data, bp_data[c]);
            check($sformatf("bp_in_ready_c%0d", c), a_if.in_ready, bp_inrdy[c]);
            @(posedge clock); #1;
        end
        a_if.out_ready = 1'b1;
        @(negedge clock);
        check("bp_idle", a_if.out_valid, 0);
        @(posedge clock); #1;

        // Short word, MSB first.
        b_if.out_ready = 1'b1;
        q_b.push_back(mk(8'h11, 1, 0)); q_b.push_back(mk(8'h22, 0, 1));
        offer(1, 32'h11223344, 2'd1);
        run_word(1, 2);

        // N=3 with an out-of-range last index clamps to 3 chunks.
        c_if.out_ready = 1'b1;
        q_c.push_back(mk(8'h11, 1, 0)); q_c.push_back(mk(8'h22, 0, 0));
        q_c.push_back(mk(8'h33, 0, 1));
        offer(2, 32'h00332211, 2'd3);
        run_word(2, 3);

        // clear after two chunks; nothing accepted during clear.
        q_a.push_back(mk(8'hAA, 1, 0)); q_a.push_back(mk(8'hBB, 0, 0));
        offer(0, 32'hDDCCBBAA, 2'd3);
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear_a = 1'b1;
        a_if.in_data = 32'h99999999; a_if.in_last_idx = 2'd3; a_if.in_valid = 1'b1;
        @(negedge clock);
        check("clr_in_ready", a_if.in_ready, 0);
        @(posedge clock); #1;
        clear_a = 1'b0;
        a_if.in_valid = 1'b0;
        @(negedge clock);
        check("clr_out_valid", a_if.out_valid, 0);
        check("clr_out_first", a_if.out_first, 0);
        @(posedge clock); #1;
        q_a.push_back(mk(8'h01, 1, 0)); q_a.push_back(mk(8'h02, 0, 0));
        q_a.push_back(mk(8'h03, 0, 0)); q_a.push_back(mk(8'h04, 0, 1));
        offer(0, 32'h04030201, 2'd3);
        run_word(0, 4);

        // Reset mid-word drops the word immediately.
        a_if.out_ready = 1'b0;
        offer(0, 32'hDDCCBBAA, 2'd3);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", a_if.out_valid, 0);
        check("mid_rst_out_data",  a_if.out_data,  0);
        check("mid_rst_out_first", a_if.out_first, 0);
        check("mid_rst_out_last",  a_if.out_last,  0);
        check("mid_rst_in_ready",  a_if.in_ready,  0);
        check("mid_rst_busy",      busy_a,         0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_release_in_ready", a_if.in_ready, 1);
        check("mid_rst_release_valid",    a_if.out_valid, 0);
        @(posedge clock); #1;
        a_if.out_ready = 1'b1;
        q_a.push_back(mk(8'hAA, 1, 0)); q_a.push_back(mk(8'hBB, 0, 0));
        q_a.push_back(mk(8'hCC, 0, 0)); q_a.push_back(mk(8'hDD, 0, 1));
        offer(0, 32'hDDCCBBAA, 2'd3);
        run_word(0, 4);

        // Every expected chunk must have been seen.
        check("queues_drained", q_a.size() + q_b.size() + q_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stream_serializer.md
# stream_serializer

Parametrised N:1 width-down converter with valid/ready flow control on both sides, programmable per-word length and selectable chunk order. It succeeds the fixed-rate 2:1 serializer in the datapath between wide internal buses and narrow links. Unlike its predecessor, it honours downstream backpressure, accepts the next word back-to-back with no idle cycle, and can emit short words of fewer than N chunks.

## Interface
Parameters:
- WIDTH, 8, bits per output chunk
- N, 4, chunks per full input word (N ≥ 2)
- MSB_FIRST, 0, 0: chunk 0 = data bits [WIDTH-1:0] goes out first; 1: most-significant chunk goes out first

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort; discards the word in flight
- in_data  in  WIDTH*N  wide input word
- in_last_idx  in  CW  index of the last chunk to emit (chunk count minus 1), where CW = max(1, ceil(log2 N))
- in_valid  in  1  in_data/in_last_idx valid
- in_ready  out  1  block accepts the word this cycle
- out_data  out  WIDTH  current chunk
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the chunk
- out_first  out  1  current chunk is the first chunk of its word
- out_last  out  1  current chunk is the last chunk of its word
- busy  out  1  word loaded (equals out_valid)

## Operation
- Internal state: shift register `store` (WIDTH*N), chunk index `idx` (CW), `last_idx` (CW), `loaded` flag.
- Input handshake fires when in_valid && in_ready. On fire: store ← in_data, idx ← 0, last_idx ← min(in_last_idx, N-1), loaded ← 1.
- in_ready = reset_n && !clear && (!loaded || (out_valid && out_ready && out_last)). This path is combinational from out_ready, which is intentional because it gives zero-bubble reload.
- Output signals are driven from registers only:
  - out_valid = loaded.
  - out_data = store[WIDTH-1:0] when MSB_FIRST=0; store[WIDTH*N-1 -: WIDTH] when MSB_FIRST=1.
  - out_first = (idx == 0).
  - out_last = (idx == last_idx).
- Output handshake fires when out_valid && out_ready:
  - If not out_last: store shifts by WIDTH toward the output end and zero-fills. idx increments.
  - If out_last and an input fire happens in the same cycle: load the new word (see input fire).
  - If out_last with no input fire: loaded ← 0.
- If out_ready is low, out_data, out_first and out_last hold stable until the chunk is accepted.
- clear (synchronous, highest priority below reset) forces loaded ← 0 and idx ← 0. in_ready is 0 during clear, so no word is accepted in that cycle. The chunk presented in the clear cycle does not count as transferred.
- in_last_idx values above N-1 (possible when N is not a power of 2) are clamped to N-1.
- When reset_n is asserted mid-word, the word is dropped with no partial output.

## Timing
- Reset values: out_valid=0, busy=0, out_first=0, out_last=0, out_data=0. in_ready=0 while reset_n is low and 1 on the first cycle after release.
- Latency: input fire at edge k puts chunk 0 on the outputs from edge k (visible in cycle k+1).
- Throughput with out_ready held at 1: exactly last_idx+1 cycles per word, with zero bubbles between consecutive words.
- in_ready can be 1 while out_valid=1 only in the cycle carrying the last chunk.
- If out_ready deasserts, the block stalls indefinitely with no data loss.

## Structure
- Shared include alongside math.v holds:
  - the CW width function, reusing CLogB2 with the N-1 argument and a floor of 1;
  - the LSB_FIRST/MSB_FIRST order constants, which are shared with the matching stream_deserializer planned later.
- The block is a single module with no sub-module. The shift-direction select is a generate on MSB_FIRST.

## Test plan
- Full word, LSB-first: WIDTH=8, N=4, in_data=0xDDCCBBAA, last_idx=3, out_ready=1 → out_data is AA, BB, CC, DD on consecutive cycles; out_first on AA; out_last on DD.
- Back-to-back: words 0x44332211 and 0x88776655 offered continuously → 8 chunks on 8 consecutive cycles; in_ready=1 exactly in the cycles carrying 0x44 and 0x88.
- Backpressure: out_ready toggled 1,0,0,1,0,1… on 0xDDCCBBAA → same 4-chunk sequence; out_data held stable through every stall; in_ready stays 0 until the last chunk transfers.
- Short word and MSB-first: MSB_FIRST=1, in_data=0x11223344, last_idx=1 → 0x11 then 0x22 with out_last on 0x22, then idle. With N=3 and last_idx=3, the index is clamped so 3 chunks are emitted.
- clear mid-word: clear asserted after 2 of 4 chunks → out_valid=0 on the next cycle; no word accepted during clear; a word offered after clear emits starting from chunk 0.
- reset_n asserted mid-word → all outputs go to 0 immediately. After release, in_ready=1 and the next word serializes correctly from chunk 0.
